// File: rtl/uart_fifo_periph.sv
// uart_fifo_periph: memory-mapped UART for the MIPS peripheral bus.
//
// Registers (full 32-bit address compare):
//   BASE_ADDR+0  TXD  write pushes wdata[7:0] into the TX FIFO; read returns last written byte
//   BASE_ADDR+4  RXD  read returns RX FIFO head (0 when empty) and pops it
//   BASE_ADDR+8  CON  [0]TX_EN [1]RX_EN [2]TX_EMPTY [3]RX_AVAIL [4]TX_BUSY [5]TX_FULL
//                     [6]RX_OVR(w1c) [7]FRAME_ERR(w1c) [8]IRQ_EN [9]PAR_ERR(w1c)
//
// Ports:
//   clk      system clock, all logic on posedge
//   reset    synchronous active-high reset
//   rd, wr   bus read / write strobes
//   addr     bus byte address
//   wdata    bus write data
//   rdata    combinational read data, 0 unless rd hits a register
//   uart_rx  asynchronous serial input
//   uart_tx  serial output, idles high
//   irq      level interrupt
//
// Build option: define UART_PARITY_EN for an even parity bit after the data bits (11-bit frame);
// otherwise frames are 10 bits and CON[9] reads 0.
module uart_fifo_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
    parameter int unsigned DIVISOR    = 651,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = $clog2(DIVISOR);
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY     = 3'd3;
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    // Bus decode
    logic sel_txd, sel_rxd, sel_con, wr_txd, wr_con;
    assign sel_txd = (addr == BASE_ADDR);
    assign sel_rxd = (addr == RXD_ADDR);
    assign sel_con = (addr == CON_ADDR);
    assign wr_txd  = wr & sel_txd;
    assign wr_con  = wr & sel_con;

    // 16x oversample tick
    logic [DW-1:0] div_q;
    logic          tick;
    assign tick = (div_q == DW'(DIVISOR - 1));
    always_ff @(posedge clk) begin
        if (reset || tick) div_q <= '0;
        else               div_q <= div_q + DW'(1);
    end

    // Control / status registers
    logic       tx_en_q, rx_en_q, irq_en_q, rx_ovr_q, frame_err_q;
    logic [7:0] txd_last_q;
    logic       rx_ovr_set, frame_set;

    // TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q;
    logic [CW-1:0] tx_cnt_q;
    logic          tx_empty, tx_full, tx_push, tx_pop;
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == DEPTH);
    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign tx_push  = wr_txd & (~tx_full | tx_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= wdata[7:0];
    end

    // TX FSM
    logic [2:0] tx_state_q, tx_bit_q;
    logic [3:0] tx_tick_q;
    logic [7:0] tx_shift_q;
    logic       tx_start_ok;
`ifdef UART_PARITY_EN
    logic       tx_par_q;
`endif
    assign tx_start_ok = tx_en_q & ~tx_empty;
    // Pop on entry to START, either from IDLE or straight out of STOP for back-to-back frames.
    assign tx_pop = tick & tx_start_ok &
                    ((tx_state_q == S_IDLE) | ((tx_state_q == S_STOP) & (tx_tick_q == 4'd15)));

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else if (tick) begin
            if (tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_tick_q == 4'd15)) begin
                tx_tick_q <= '0;
                if (tx_start_ok) begin
                    tx_state_q <= S_START;
                    tx_shift_q <= tx_mem[tx_rp_q];
`ifdef UART_PARITY_EN
                    tx_par_q   <= ^tx_mem[tx_rp_q];
`endif
                end else begin
                    tx_state_q <= S_IDLE;
                end
            end else begin
                tx_tick_q <= tx_tick_q + 4'd1;
                if (tx_tick_q == 4'd15) begin
                    case (tx_state_q)
                        S_START: begin
                            tx_state_q <= S_DATA;
                            tx_bit_q   <= '0;
                        end
                        S_DATA: begin
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            if (tx_bit_q == 3'd7) tx_state_q <= S_AFTER_DATA;
                        end
`ifdef UART_PARITY_EN
                        S_PARITY: tx_state_q <= S_STOP;
`endif
                        default: tx_state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        case (tx_state_q)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = tx_shift_q[0];
`ifdef UART_PARITY_EN
            S_PARITY: uart_tx = tx_par_q;
`endif
            default: uart_tx = 1'b1;
        endcase
    end

    // RX synchroniser
    logic rx_s1_q, rx_s2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= uart_rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    // RX FIFO
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_rp_q;
    logic [CW-1:0] rx_cnt_q;
    logic          rx_empty, rx_full, rx_push_req, rx_push, rx_pop;
    assign rx_empty   = (rx_cnt_q == '0);
    assign rx_full    = (rx_cnt_q == DEPTH);
    assign rx_pop     = rd & sel_rxd & ~rx_empty;
    assign rx_push    = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovr_set = rx_push_req & rx_full & ~rx_pop;

    // RX FSM
    logic [2:0] rx_state_q, rx_bit_q;
    logic [3:0] rx_tick_q;
    logic [7:0] rx_shift_q;
    logic       rx_abort, rx_sample, rx_stop_sample;
    // Clearing RX_EN drops the frame in the same cycle as the CON write.
    assign rx_abort       = ~rx_en_q | (wr_con & ~wdata[1]);
    assign rx_sample      = tick & (rx_tick_q == 4'd7);
    assign rx_stop_sample = ~rx_abort & rx_sample & (rx_state_q == S_STOP);
    assign frame_set      = rx_stop_sample & ~rx_s2_q;
`ifdef UART_PARITY_EN
    logic rx_par_bad_q, par_set, par_err_q;
    assign par_set     = ~rx_abort & rx_sample & (rx_state_q == S_PARITY) &
                         (rx_s2_q != ^rx_shift_q);
    assign rx_push_req = rx_stop_sample & rx_s2_q & ~rx_par_bad_q;
`else
    assign rx_push_req = rx_stop_sample & rx_s2_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else if (rx_abort) begin
            rx_state_q <= S_IDLE;
            rx_tick_q  <= '0;
        end else if (rx_state_q == S_IDLE) begin
            if (!rx_s2_q) begin
                rx_state_q <= S_START;
                rx_tick_q  <= '0;
            end
        end else if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            case (rx_state_q)
                S_START: begin
                    if (rx_tick_q == 4'd7 && rx_s2_q) begin
                        rx_state_q <= S_IDLE;  // false start
                    end else if (rx_tick_q == 4'd15) begin
                        rx_state_q <= S_DATA;
                        rx_bit_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (rx_tick_q == 4'd7) rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_tick_q == 4'd15) begin
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= S_AFTER_DATA;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: if (rx_tick_q == 4'd15) rx_state_q <= S_STOP;
`endif
                // Return to IDLE at the stop sample so the next start edge is caught early.
                S_STOP:  if (rx_tick_q == 4'd7) rx_state_q <= S_IDLE;
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_par_bad_q <= 1'b0;
            par_err_q    <= 1'b0;
        end else begin
            if (rx_sample && rx_state_q == S_PARITY) rx_par_bad_q <= (rx_s2_q != ^rx_shift_q);
            par_err_q <= (par_err_q & ~(wr_con & wdata[9])) | par_set;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_shift_q;
    end

    // Sticky flags: a hardware set wins over a clearing write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en_q     <= 1'b1;
            rx_en_q     <= 1'b1;
            irq_en_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            txd_last_q  <= '0;
        end else begin
            if (wr_con) begin
                tx_en_q  <= wdata[0];
                rx_en_q  <= wdata[1];
                irq_en_q <= wdata[8];
            end
            if (wr_txd) txd_last_q <= wdata[7:0];
            rx_ovr_q    <= (rx_ovr_q & ~(wr_con & wdata[6])) | rx_ovr_set;
            frame_err_q <= (frame_err_q & ~(wr_con & wdata[7])) | frame_set;
        end
    end

    // Read mux
    logic [31:0] con_word;
    always_comb begin
        con_word    = '0;
        con_word[0] = tx_en_q;
        con_word[1] = rx_en_q;
        con_word[2] = tx_empty;
        con_word[3] = ~rx_empty;
        con_word[4] = (tx_state_q != S_IDLE);
        con_word[5] = tx_full;
        con_word[6] = rx_ovr_q;
        con_word[7] = frame_err_q;
        con_word[8] = irq_en_q;
`ifdef UART_PARITY_EN
        con_word[9] = par_err_q;
`endif
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd)      rdata = {24'b0, txd_last_q};
            else if (sel_rxd) rdata = rx_empty ? 32'b0 : {24'b0, rx_mem[rx_rp_q]};
            else if (sel_con) rdata = con_word;
        end
    end

`ifdef UART_PARITY_EN
    assign irq = irq_en_q & (~rx_empty | rx_ovr_q | frame_err_q | par_err_q);
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:10];
`else
    assign irq = irq_en_q & (~rx_empty | rx_ovr_q | frame_err_q);
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:9];
`endif

endmodule

// File: tb/tb_uart_fifo_periph.sv
module tb_uart_fifo_periph;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        clk, reset, rd, wr, uart_rx, uart_tx, irq;
    logic [31:0] addr, wdata, rdata, d;
    int          checks = 0;
    int          failures = 0;

    uart_fifo_periph #(
        .BASE_ADDR (TXD),
        .DIVISOR   (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = v;
        @(negedge clk);
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    // Read with a clock edge (pops RXD).
    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        rd = 1'b1; addr = a;
        #1 v = rdata;
        @(negedge clk);
        rd = 1'b0; addr = '0;
    endtask

    // Combinational look without a clock edge.
    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        rd = 1'b1; addr = a;
        #1 v = rdata;
        rd = 1'b0; addr = '0;
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (uart_tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, uart_tx}, 32'd0);
    endtask

    // Entered half a clock after the start edge; leaves half a clock after the next frame slot.
    task automatic check_frame(input logic [7:0] exp, input string tag);
        logic [7:0] got;
        logic       sb, se, pb;
        repeat (32) @(negedge clk);
        sb = uart_tx;
        repeat (31) @(negedge clk);
        se = uart_tx;  // last half-clock of the start bit
        for (int i = 0; i < 8; i++) begin
            repeat ((i == 0) ? 32 : 64) @(negedge clk);
            got[i] = uart_tx;
        end
`ifdef UART_PARITY_EN
        repeat (64) @(negedge clk);
        chk({tag, "_par"}, {31'b0, uart_tx}, {31'b0, ^exp});
`endif
        repeat (64) @(negedge clk);
        pb = uart_tx;
        chk({tag, "_start"}, {31'b0, sb}, 32'd0);
        chk({tag, "_start_end"}, {31'b0, se}, 32'd0);
        chk({tag, "_data"}, {24'b0, got}, {24'b0, exp});
        chk({tag, "_stop"}, {31'b0, pb}, 32'd1);
        repeat (33) @(negedge clk);
    endtask

    // Serial frame into uart_rx; a bad stop bit is low for 40 clk only.
    task automatic send_rx(input logic [7:0] b, input logic good_stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (64) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        uart_rx = ^b;
        repeat (64) @(negedge clk);
`endif
        if (good_stop) begin
            uart_rx = 1'b1;
            repeat (64) @(negedge clk);
        end else begin
            uart_rx = 1'b0;
            repeat (40) @(negedge clk);
            uart_rx = 1'b1;
            repeat (24) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        peek(CON, d); chk("rst_con", d, 32'h0000_0007);
        peek(RXD, d); chk("rst_rxd", d, 32'h0);
        peek(TXD, d); chk("rst_txd", d, 32'h0);
        peek(32'h4000_0024, d); chk("unmapped", d, 32'h0);

        // Single TX frame 0xA5
        bus_write(TXD, 32'h0000_00A5);
        wait_fall("a5_fall");
        peek(CON, d); chk("a5_con_busy", d, 32'h0000_0017);
        check_frame(8'hA5, "a5");
        peek(CON, d); chk("a5_con_done", d, 32'h0000_0007);
        peek(TXD, d); chk("a5_txd", d, 32'h0000_00A5);

        // FIFO full with TX disabled, then four back-to-back frames
        bus_write(CON, 32'h0000_0002);
        bus_write(TXD, 32'h11);
        bus_write(TXD, 32'h22);
        bus_write(TXD, 32'h33);
        bus_write(TXD, 32'h44);
        peek(CON, d); chk("full_con", d, 32'h0000_0022);
        bus_write(TXD, 32'h55);
        peek(CON, d); chk("full_con2", d, 32'h0000_0022);
        repeat (100) @(negedge clk);
        chk("txdis_idle", {31'b0, uart_tx}, 32'd1);
        bus_write(CON, 32'h0000_0003);
        wait_fall("b2b_fall");
        check_frame(8'h11, "b2b0");
        check_frame(8'h22, "b2b1");
        check_frame(8'h33, "b2b2");
        check_frame(8'h44, "b2b3");
        chk("b2b_idle", {31'b0, uart_tx}, 32'd1);
        peek(CON, d); chk("b2b_con", d, 32'h0000_0007);

        // RX single frame and irq
        send_rx(8'h3C, 1'b1);
        peek(CON, d); chk("rx_avail", d, 32'h0000_000F);
        chk("rx_irq_off", {31'b0, irq}, 32'd0);
        bus_write(CON, 32'h0000_0103);
        chk("rx_irq_on", {31'b0, irq}, 32'd1);
        bus_read(RXD, d); chk("rx_data", d, 32'h0000_003C);
        chk("rx_irq_clr", {31'b0, irq}, 32'd0);
        bus_read(RXD, d); chk("rx_empty_rd", d, 32'h0);
        peek(CON, d); chk("rx_con_empty", d, 32'h0000_0107);

        // RX overrun
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
        peek(CON, d); chk("ovr_con", d, 32'h0000_014F);
        chk("ovr_irq", {31'b0, irq}, 32'd1);
        bus_write(CON, 32'h0000_0143);
        peek(CON, d); chk("ovr_clr", d, 32'h0000_010F);
        for (int i = 1; i <= 4; i++) begin
            bus_read(RXD, d); chk("ovr_data", d, 32'(i));
        end
        peek(CON, d); chk("ovr_drained", d, 32'h0000_0107);
        chk("ovr_irq_clr", {31'b0, irq}, 32'd0);

        // Glitch rejection
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        peek(CON, d); chk("glitch_con", d, 32'h0000_0107);
        chk("glitch_irq", {31'b0, irq}, 32'd0);

        // Framing error
        send_rx(8'h5A, 1'b0);
        repeat (100) @(negedge clk);
        peek(CON, d); chk("ferr_con", d, 32'h0000_0187);
        chk("ferr_irq", {31'b0, irq}, 32'd1);
        bus_write(CON, 32'h0000_0183);
        peek(CON, d); chk("ferr_clr", d, 32'h0000_0107);

        // Reset mid-frame
        bus_write(TXD, 32'h0000_005A);
        wait_fall("rst_fall");
        repeat (100) @(negedge clk);
        chk("rst_mid_low", {31'b0, uart_tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", {31'b0, uart_tx}, 32'd1);
        peek(CON, d); chk("rst_mid_con", d, 32'h0000_0007);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("rst_after_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_after_irq", {31'b0, irq}, 32'd0);
        peek(CON, d); chk("rst_after_con", d, 32'h0000_0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
